// File: rtl/idelay_tap_calibrator.sv
`default_nettype none
// ============================================================================
// Module      : idelay_tap_calibrator
// Description : Load-side controller for a VAR_LOAD input delay element.
//               On i_start it loads taps 0..31 one at a time. For each tap it
//               waits a settle time and then evaluates SAMPLE_COUNT qualified
//               pass/fail samples. It tracks the widest contiguous passing
//               window, with the earliest window winning a tie. At the end it
//               loads the window centre, or tap 0 when the best window is
//               shorter than MIN_WINDOW.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_controller_clk : clock; delay-line load interface is consumed on rising edge
//   i_rst            : synchronous active-high reset
//   i_start          : start calibration (honoured in IDLE or DONE only)
//   i_sample_valid   : one sample of delayed data available this cycle
//   i_sample_match   : sampled data equals expected pattern (qualified by valid)
//   o_cntvaluein     : tap value to delay line, stable whenever o_ld = 0
//   o_ld             : single-cycle load strobe
//   o_busy           : sweep in progress
//   o_done           : calibration finished, held until next start or reset
//   o_fail           : best window shorter than MIN_WINDOW (valid with o_done)
//   o_best_tap       : final loaded tap
//   o_window_len     : length of best passing window (0..32)
// ============================================================================
module idelay_tap_calibrator #(
  parameter int SETTLE_CYCLES = 8,   // idle cycles after each load (1..255)
  parameter int SAMPLE_COUNT  = 16,  // valid samples evaluated per tap (1..255)
  parameter int MIN_WINDOW    = 4    // minimum window for success (1..32)
) (
  input  logic       i_controller_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_sample_valid,
  input  logic       i_sample_match,
  output logic [4:0] o_cntvaluein,
  output logic       o_ld,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [4:0] o_best_tap,
  output logic [5:0] o_window_len
);

  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);
  localparam logic [5:0] c_MIN_WINDOW  = 6'(MIN_WINDOW);
  localparam logic [4:0] c_LAST_TAP    = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_EVAL   = 3'd4,
    S_FINAL  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t     r_state;
  logic [4:0] r_tap;
  logic [7:0] r_settle_cnt;
  logic [7:0] r_sample_cnt;
  logic       r_tap_pass;
  logic [4:0] r_cur_start;
  logic [5:0] r_cur_len;
  logic [4:0] r_best_start;
  logic [5:0] r_best_len;

  logic [4:0] r_cntvaluein;
  logic       r_ld;
  logic       r_busy;
  logic       r_done;
  logic       r_fail;
  logic [4:0] r_best_tap;
  logic [5:0] r_window_len;

  // Window bookkeeping as it will stand after the current EVAL cycle. The
  // final centre is derived from these next-state values, so the final load
  // strobe can be raised on the same edge that leaves EVAL for tap 31. This
  // keeps the final o_ld in the FINAL cycle and o_done in the cycle after.
  logic [5:0] w_next_cur_len;
  logic [4:0] w_next_cur_start;
  logic       w_best_update;
  logic [5:0] w_next_best_len;
  logic [4:0] w_next_best_start;
  logic [5:0] w_half_len;
  logic [4:0] w_centre;
  logic       w_window_ok;

  always_comb begin
    w_next_cur_len    = 6'd0;
    w_next_cur_start  = r_cur_start;
    w_best_update     = 1'b0;
    w_next_best_len   = r_best_len;
    w_next_best_start = r_best_start;
    w_half_len        = 6'd0;
    w_centre          = 5'd0;
    w_window_ok       = 1'b0;

    if (r_tap_pass) begin
      w_next_cur_len = r_cur_len + 6'd1;
      // A new window opens on the first passing tap after a failure.
      if (r_cur_len == 6'd0) begin
        w_next_cur_start = r_tap;
      end
    end

    // Strictly greater: an equal-length later window never displaces the
    // earlier one.
    w_best_update = r_tap_pass && (w_next_cur_len > r_best_len);
    if (w_best_update) begin
      w_next_best_len   = w_next_cur_len;
      w_next_best_start = w_next_cur_start;
    end

    w_window_ok = (w_next_best_len >= c_MIN_WINDOW);
    if (w_next_best_len != 6'd0) begin
      w_half_len = (w_next_best_len - 6'd1) >> 1;
    end
    // Sum formed at 6 bits, then truncated to a 5-bit tap.
    w_centre = 5'({1'b0, w_next_best_start} + w_half_len);
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_tap        <= 5'd0;
      r_settle_cnt <= 8'd0;
      r_sample_cnt <= 8'd0;
      r_tap_pass   <= 1'b0;
      r_cur_start  <= 5'd0;
      r_cur_len    <= 6'd0;
      r_best_start <= 5'd0;
      r_best_len   <= 6'd0;
      r_cntvaluein <= 5'd0;
      r_ld         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_best_tap   <= 5'd0;
      r_window_len <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_tap        <= 5'd0;
            r_cur_start  <= 5'd0;
            r_cur_len    <= 6'd0;
            r_best_start <= 5'd0;
            r_best_len   <= 6'd0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b1;
            // Strobe is registered, so it is presented during LOAD.
            r_cntvaluein <= 5'd0;
            r_ld         <= 1'b1;
            r_state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_ld         <= 1'b0;
          r_settle_cnt <= 8'd0;
          r_sample_cnt <= 8'd0;
          r_tap_pass   <= 1'b1;
          r_state      <= S_SETTLE;
        end

        S_SETTLE: begin
          // Samples arriving while the delay line settles are ignored.
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_settle_cnt <= 8'd0;
            r_state      <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end

        S_SAMPLE: begin
          if (i_sample_valid) begin
            r_tap_pass <= r_tap_pass & i_sample_match;
            if (r_sample_cnt == c_SAMPLE_LAST) begin
              r_sample_cnt <= 8'd0;
              r_state      <= S_EVAL;
            end else begin
              r_sample_cnt <= r_sample_cnt + 8'd1;
            end
          end
        end

        S_EVAL: begin
          r_cur_len    <= w_next_cur_len;
          r_cur_start  <= w_next_cur_start;
          r_best_len   <= w_next_best_len;
          r_best_start <= w_next_best_start;
          if (r_tap == c_LAST_TAP) begin
            r_ld         <= 1'b1;
            r_cntvaluein <= w_window_ok ? w_centre : 5'd0;
            r_best_tap   <= w_window_ok ? w_centre : 5'd0;
            r_window_len <= w_next_best_len;
            r_fail       <= ~w_window_ok;
            r_state      <= S_FINAL;
          end else begin
            r_tap        <= r_tap + 5'd1;
            r_cntvaluein <= r_tap + 5'd1;
            r_ld         <= 1'b1;
            r_state      <= S_LOAD;
          end
        end

        S_FINAL: begin
          r_ld    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cntvaluein = r_cntvaluein;
  assign o_ld         = r_ld;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fail       = r_fail;
  assign o_best_tap   = r_best_tap;
  assign o_window_len = r_window_len;

endmodule
`default_nettype wire

// File: tb/tb_idelay_tap_calibrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_idelay_tap_calibrator
// Description : Self-checking bench for idelay_tap_calibrator. A table of
//               per-tap pass masks with expected results, randomized masks
//               checked against a window-search reference model, and
//               hand-written sequences for settle/sample qualification,
//               start-while-busy and mid-sweep reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idelay_tap_calibrator;

  localparam int S    = 8;
  localparam int N    = 16;
  localparam int MINW = 4;

  logic       clk = 1'b0;
  logic       rst, start, sv, sm;
  logic [4:0] o_cntvaluein;
  logic       o_ld, o_busy, o_done, o_fail;
  logic [4:0] o_best_tap;
  logic [5:0] o_window_len;

  idelay_tap_calibrator #(
    .SETTLE_CYCLES(S),
    .SAMPLE_COUNT (N),
    .MIN_WINDOW   (MINW)
  ) dut (
    .i_controller_clk(clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_sample_valid  (sv),
    .i_sample_match  (sm),
    .o_cntvaluein    (o_cntvaluein),
    .o_ld            (o_ld),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_fail          (o_fail),
    .o_best_tap      (o_best_tap),
    .o_window_len    (o_window_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    int          exp_len;
    int          exp_tap;
    bit          exp_fail;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int ld_vals[$];
  bit timed_out;
  bit done_after_ld;
  bit busy_at_done;
  int busy_gaps;
  int bad_tap[2];
  int bad_idx[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: enumerate maximal passing runs, keep the longest, earliest on tie.
  function automatic void ref_cal(input logic [31:0] m, output int len,
                                  output int tap, output bit fail);
    int bl = 0;
    int bs = 0;
    for (int a = 0; a < 32; a++) begin
      if (m[a] && (a == 0 || !m[a-1])) begin
        int b = a;
        while (b < 32 && m[b]) b++;
        if (b - a > bl) begin
          bl = b - a;
          bs = a;
        end
      end
    end
    len  = bl;
    fail = (bl < MINW);
    tap  = fail ? 0 : ((bs + (bl - 1) / 2) % 32);
  endfunction

  // Starts a calibration and plays the sample source until DONE, a reset
  // injection point, or the cycle budget runs out.
  task automatic run_cal(input logic [31:0] mask, input bit rand_valid,
                         input bit noise, input int busy_start_tap,
                         input int rst_tap);
    int  since_ld = 0;
    int  cyc = 0;
    int  tap;
    bit  finished = 0;
    bit  prev_ld = 0;
    ld_vals.delete();
    timed_out = 0; done_after_ld = 0; busy_at_done = 1; busy_gaps = 0;
    @(negedge clk);
    start = 1'b1; sv = 1'b0; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!finished) begin
      if (o_ld) begin
        ld_vals.push_back(int'(o_cntvaluein));
        since_ld = 0;
      end else begin
        since_ld++;
      end
      if (o_done) begin
        done_after_ld = prev_ld;
        busy_at_done  = o_busy;
        finished      = 1;
      end else if (!o_busy) begin
        busy_gaps++;
      end
      prev_ld = o_ld;
      tap     = int'(o_cntvaluein);

      start = 1'b0;
      sv    = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      sm    = mask[tap];
      if (!sv) sm = 1'($urandom_range(0, 1));
      if (noise && since_ld <= S) sm = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        if (tap == bad_tap[k] && since_ld == bad_idx[k]) begin
          sv = 1'b1;
          sm = 1'b0;
        end
      end
      if (tap == busy_start_tap && since_ld == 5) start = 1'b1;
      if (tap == rst_tap && since_ld == 4) begin
        rst      = 1'b1;
        finished = 1;
      end
      cyc++;
      if (cyc > 6000) begin
        timed_out = 1;
        finished  = 1;
      end
      @(negedge clk);
    end
    sv = 1'b0; sm = 1'b0; start = 1'b0;
  endtask

  task automatic check_run(input string nm, input int exp_len,
                           input int exp_tap, input bit exp_fail);
    int seq_err = 0;
    int extra_ld = 0;
    chk({nm, ".timeout"}, int'(timed_out), 0);
    chk({nm, ".ld_count"}, ld_vals.size(), 33);
    for (int i = 0; i < 32; i++) begin
      if (i >= ld_vals.size() || ld_vals[i] != i) seq_err++;
    end
    chk({nm, ".ld_seq_err"}, seq_err, 0);
    chk({nm, ".final_load"}, (ld_vals.size() >= 33) ? ld_vals[32] : -1, exp_tap);
    chk({nm, ".best_tap"}, int'(o_best_tap), exp_tap);
    chk({nm, ".window_len"}, int'(o_window_len), exp_len);
    chk({nm, ".fail"}, int'(o_fail), int'(exp_fail));
    chk({nm, ".done_after_ld"}, int'(done_after_ld), 1);
    chk({nm, ".busy_at_done"}, int'(busy_at_done), 0);
    chk({nm, ".busy_gaps"}, busy_gaps, 0);
    repeat (5) begin
      @(negedge clk);
      if (o_ld) extra_ld++;
    end
    chk({nm, ".done_hold"}, int'(o_done), 1);
    chk({nm, ".ld_after_done"}, extra_ld, 0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] m;
    int          rl, rt;
    bit          rf;
    int          ld_seen;

    vecs[0] = '{32'hFFFF_FFFF, 32, 15, 1'b0};  // all pass
    vecs[1] = '{32'h0FF0_003C,  8, 23, 1'b0};  // 2..5 and 20..27
    vecs[2] = '{32'h0000_F078,  4,  4, 1'b0};  // tie 3..6 vs 12..15
    vecs[3] = '{32'h0000_0700,  3,  0, 1'b1};  // too short
    vecs[4] = '{32'h0000_0000,  0,  0, 1'b1};  // nothing passes
    vecs[5] = '{32'hF000_0000,  4, 29, 1'b0};  // window open at tap 31

    bad_tap = '{-1, -1};
    bad_idx = '{-1, -1};
    rst = 1'b1; start = 1'b0; sv = 1'b0; sm = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.ld", int'(o_ld), 0);
    chk("reset.busy", int'(o_busy), 0);
    chk("reset.done", int'(o_done), 0);
    chk("reset.window_len", int'(o_window_len), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_cal(vecs[i].mask, 1'b0, 1'b0, -1, -1);
      check_run($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_tap,
                vecs[i].exp_fail);
    end

    // Tap 17: mismatching valid during settle (discarded).
    // Tap 18: 7th of 16 sample pulses mismatches.
    bad_tap = '{18, 17};
    bad_idx = '{S + 7, 3};
    run_cal(32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1);
    check_run("tap18_glitch", 18, 8, 1'b0);
    bad_tap = '{-1, -1};
    bad_idx = '{-1, -1};

    // Start pulse while busy at tap 3, then reset during tap 12.
    run_cal(32'hFFFF_FFFF, 1'b0, 1'b0, 3, 12);
    chk("rstseq.timeout", int'(timed_out), 0);
    chk("rstseq.ld_count", ld_vals.size(), 13);
    begin
      int seq_err = 0;
      for (int i = 0; i < ld_vals.size(); i++) if (ld_vals[i] != i) seq_err++;
      chk("rstseq.ld_seq_err", seq_err, 0);
    end
    chk("rstseq.cntvaluein", int'(o_cntvaluein), 0);
    chk("rstseq.ld", int'(o_ld), 0);
    chk("rstseq.busy", int'(o_busy), 0);
    chk("rstseq.done", int'(o_done), 0);
    chk("rstseq.fail", int'(o_fail), 0);
    chk("rstseq.best_tap", int'(o_best_tap), 0);
    chk("rstseq.window_len", int'(o_window_len), 0);
    rst = 1'b0;
    ld_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_ld || o_busy) ld_seen++;
    end
    chk("rstseq.quiet_after_reset", ld_seen, 0);
    run_cal(32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1);
    check_run("restart", 32, 15, 1'b0);

    // Randomized masks, gapped valid, noise during settle.
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0: m = $urandom();
        1: begin
          m = '0;
          repeat ($urandom_range(1, 3)) begin
            int a = $urandom_range(0, 31);
            int l = $urandom_range(1, 12);
            for (int i = a; i < 32 && i < a + l; i++) m[i] = 1'b1;
          end
        end
        default: m = ~($urandom() & $urandom() & $urandom());
      endcase
      ref_cal(m, rl, rt, rf);
      run_cal(m, 1'b1, 1'b1, -1, -1);
      check_run($sformatf("rand%0d_%08h", r, m), rl, rt, rf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idelay_tap_calibrator.md
Name: idelay_tap_calibrator

Overview:
Drives the load side of a VAR_LOAD input delay element: o_cntvaluein/o_ld connect to the delay line's CNTVALUEIN/LD, and sampling logic reports the pass/fail of the delayed data back. On request it sweeps all 32 taps and finds the widest contiguous passing window. It then loads the window centre as the final tap. It sits between the read-calibration sequencer and each lane's IDELAY.

Parameters:
SETTLE_CYCLES, 8, idle cycles after each tap load before samples count (1..255)
SAMPLE_COUNT, 16, i_sample_valid pulses evaluated per tap (1..255)
MIN_WINDOW, 4, minimum passing-window length (taps) for success (1..32)

Ports:
i_controller_clk  input  1  clock; o_cntvaluein/o_ld are consumed on this clock's rising edge
i_rst  input  1  synchronous active-high reset
i_start  input  1  start calibration; sampled only in IDLE or DONE
i_sample_valid  input  1  one sample of delayed data is available this cycle
i_sample_match  input  1  sampled data equals expected pattern; qualified by i_sample_valid
o_cntvaluein  output  5  tap value to delay line; held stable whenever o_ld=0
o_ld  output  1  single-cycle load strobe
o_busy  output  1  sweep in progress
o_done  output  1  calibration finished; held until next start or reset
o_fail  output  1  best window < MIN_WINDOW; valid when o_done=1
o_best_tap  output  5  final loaded tap
o_window_len  output  6  length of best window (0..32)

Behaviour:
- All outputs are registered. Reset values: o_cntvaluein=0, o_ld=0, o_busy=0, o_done=0, o_fail=0, o_best_tap=0, o_window_len=0, FSM=IDLE, all internal counters 0.
- Reset has priority over every other input, in every state. After reset, the next edge returns to the reset values. No further o_ld is issued until a new i_start.
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE.
- IDLE/DONE: on i_start=1, set tap=0 and clear cur_start, cur_len, best_start and best_len. Clear o_done and o_fail, set o_busy=1, and go to LOAD.
- i_start is ignored in all other states.
- LOAD: drive o_cntvaluein=tap with o_ld=1 for exactly one cycle, then go to SETTLE.
- o_ld therefore appears the cycle after i_start is sampled.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE. i_sample_valid pulses received in this state are discarded.
- SAMPLE: count valid pulses. tap_pass = AND of i_sample_match over the SAMPLE_COUNT valid pulses. After the last counted pulse, go to EVAL. There is no timeout: the FSM waits indefinitely for pulses.
- EVAL, when tap_pass=1:
  - if cur_len==0, set cur_start=tap;
  - increment cur_len;
  - if the new cur_len > best_len (strict), copy it to best_start/best_len.
  - Strict comparison means the earliest window wins ties.
- EVAL, when tap_pass=0: set cur_len=0.
- EVAL, then: if tap==31, go to FINAL. Otherwise increment tap and go to LOAD. Tap never wraps.
- A window still open at tap 31 is counted, because the best values update on every passing tap.
- FINAL when best_len >= MIN_WINDOW: centre = best_start + ((best_len-1)>>1), computed 6-bit and truncated to 5 bits. Load centre (o_ld=1 for one cycle), set o_best_tap=centre, o_window_len=best_len, o_fail=0.
- FINAL when best_len < MIN_WINDOW: load tap 0, set o_best_tap=0, o_window_len=best_len, o_fail=1.
- FINAL, then: go to DONE. In DONE, o_busy=0 and o_done=1, asserted the cycle after the final o_ld.
- Per-tap duration with i_sample_valid held high: 1 (LOAD) + SETTLE_CYCLES + SAMPLE_COUNT + 1 (EVAL).
- Total strobes per run: exactly 33 o_ld pulses (32 sweep loads + 1 final).

Test Plan:
- Defaults, i_sample_valid=1, i_sample_match=1 always -> 33 o_ld pulses, with o_cntvaluein 0..31 then 15; o_window_len=32, o_best_tap=15, o_fail=0, o_done=1.
- Match only at taps 2..5 and 20..27 -> o_window_len=8, o_best_tap=23, final o_cntvaluein=23.
- Tie case: passing taps 3..6 and 12..15 -> earliest window wins; o_best_tap=4, o_window_len=4.
- Passing taps 8..10 only (len 3 < 4) -> o_fail=1, o_best_tap=0, o_window_len=3, final load value 0.
- At tap 18 of an all-pass run, one mismatching sample (the 7th of 16) plus a mismatching valid during SETTLE at tap 17 -> tap 17 still passes and tap 18 fails. Expect windows 0..17 and 19..31, o_window_len=18, o_best_tap=8.
- Reset and start handling, three steps:
  - pulse i_start while busy -> ignored;
  - assert i_rst during tap 12 -> all outputs at reset values next edge, no o_ld until restart;
  - new i_start with all-pass -> o_best_tap=15.
